gray_code_codec_pipe: RTL and testbench

Parametrised, pipelined binary/Gray converter that handles both encoding (binary->Gray) and decoding (Gray->binary), selected per transaction.
It sits between streaming producer/consumer blocks such as counters, CDC pointer paths and position encoders.
It uses valid/ready handshakes on both sides with full backpressure, has a fixed 2-cycle latency, and sustains one transaction per clock.

---
 rtl/gray_code_codec_pipe.sv | 92 +++++++++
 tb/tb_gray_code_codec_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_codec_pipe.sv
// Two-stage valid/ready pipeline converting binary<->Gray per beat.
// S1 captures the input; the conversion sits between S1 and S2.
module gray_code_codec_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_mode_q, s2_mode_d;

    logic             s2_free;
    logic             s1_move;
    logic             accept;
    logic [WIDTH-1:0] conv;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;

    // Decode bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        conv = '0;
        if (s1_mode_q) begin
            for (int i = 0; i < WIDTH; i++) begin
                conv[i] = ^(s1_data_q >> i);
            end
        end else begin
            conv = s1_data_q ^ (s1_data_q >> 1);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_mode_d  = s2_mode_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_mode_d  = in_mode;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
        if (s1_move) begin
            s2_valid_d = 1'b1;
            s2_data_d  = conv;
            s2_mode_d  = s1_mode_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mode_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_mode_q  <= s2_mode_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_mode  = s2_mode_q;

endmodule

// File: tb/tb_gray_code_codec_pipe.sv
// Directed vector bench for gray_code_codec_pipe at WIDTH=4 and WIDTH=8.
module tb_gray_code_codec_pipe;

    typedef struct {
        logic       mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    logic clk;
    logic rst;

    logic       iv4, ir4, im4, ov4, or4, om4;
    logic [3:0] id4, od4;
    logic       iv8, ir8, im8, ov8, or8, om8;
    logic [7:0] id8, od8;

    int   n_vec;
    int   n_err;
    vec_t cur[$];

    gray_code_codec_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_mode(im4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_mode(om4)
    );

    gray_code_codec_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_mode(om8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic v, input logic m,
                         input logic [7:0] d);
        if (w8) begin
            iv8 = v; im8 = m; id8 = d;
        end else begin
            iv4 = v; im4 = m; id4 = d[3:0];
        end
    endtask

    function automatic logic get_ov(input bit w8);
        return w8 ? ov8 : ov4;
    endfunction

    function automatic logic get_ir(input bit w8);
        return w8 ? ir8 : ir4;
    endfunction

    function automatic logic get_om(input bit w8);
        return w8 ? om8 : om4;
    endfunction

    function automatic logic [7:0] get_od(input bit w8);
        return w8 ? od8 : {4'b0, od4};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams cur[] back to back with out_ready high; beat k shows up
    // two edges after it is driven.
    task automatic run_stream(input bit w8);
        int n;
        n = cur.size();
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) drive(w8, 1'b1, cur[k].mode, cur[k].din);
            else drive(w8, 1'b0, 1'b0, 8'h00);
            @(negedge clk);
            chk("stream_in_ready", get_ir(w8), 1);
            if (k >= 2) begin
                chk("stream_valid", get_ov(w8), 1);
                chk("stream_data", get_od(w8), cur[k-2].dout);
                chk("stream_mode", get_om(w8), cur[k-2].mode);
            end else begin
                chk("stream_idle", get_ov(w8), 0);
            end
            step();
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [7:0] di,
                                input logic [7:0] dq);
        vec_t v;
        v.mode = m; v.din = di; v.dout = dq;
        return v;
    endfunction

    initial begin
        logic [3:0] b;
        logic [3:0] g;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        or4 = 1'b1;
        or8 = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid4", ov4, 0);
        chk("rst_data4", od4, 0);
        chk("rst_mode4", om4, 0);
        chk("rst_ready4", ir4, 1);
        chk("rst_valid8", ov8, 0);
        chk("rst_ready8", ir8, 1);
        step();

        cur.delete();
        cur.push_back(mk(0, 8'b1011, 8'b1110));
        cur.push_back(mk(0, 8'b0111, 8'b0100));
        cur.push_back(mk(1, 8'b1110, 8'b1011));
        for (int i = 0; i < 16; i++) begin
            b = 4'(i);
            g = b ^ (b >> 1);
            cur.push_back(mk(0, {4'b0, b}, {4'b0, g}));
            cur.push_back(mk(1, {4'b0, g}, {4'b0, b}));
        end
        run_stream(0);

        cur.delete();
        cur.push_back(mk(0, 8'hFF, 8'h80));
        cur.push_back(mk(1, 8'h80, 8'hFF));
        cur.push_back(mk(0, 8'h00, 8'h00));
        cur.push_back(mk(1, 8'hB4, 8'hD8));
        run_stream(1);

        // Backpressure: A=enc 1 -> 1, B=enc 2 -> 3, C=dec 3 -> 2.
        or4 = 1'b0;
        drive(0, 1, 0, 8'h1);
        @(negedge clk);
        chk("bp_ready_a", ir4, 1);
        step();
        drive(0, 1, 0, 8'h2);
        @(negedge clk);
        chk("bp_ready_b", ir4, 1);
        step();
        drive(0, 1, 1, 8'h3);
        @(negedge clk);
        chk("bp_full_ready", ir4, 0);
        chk("bp_hold_valid", ov4, 1);
        chk("bp_hold_data", od4, 4'h1);
        chk("bp_hold_mode", om4, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            chk("bp_stall_ready", ir4, 0);
            chk("bp_stall_valid", ov4, 1);
            chk("bp_stall_data", od4, 4'h1);
        end
        step();
        or4 = 1'b1;
        #1;
        chk("bp_release_ready", ir4, 1);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("bp_drain_b_valid", ov4, 1);
        chk("bp_drain_b_data", od4, 4'h3);
        chk("bp_drain_b_mode", om4, 0);
        step();
        @(negedge clk);
        chk("bp_drain_c_valid", ov4, 1);
        chk("bp_drain_c_data", od4, 4'h2);
        chk("bp_drain_c_mode", om4, 1);
        step();
        @(negedge clk);
        chk("bp_empty", ov4, 0);
        chk("bp_empty_ready", ir4, 1);

        // Mid-stream reset with both stages full.
        step();
        or4 = 1'b0;
        drive(0, 1, 0, 8'h5);
        step();
        drive(0, 1, 1, 8'h6);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("mr_full_ready", ir4, 0);
        chk("mr_full_valid", ov4, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_valid", ov4, 0);
        chk("mr_ready", ir4, 1);
        chk("mr_data", od4, 0);
        or4 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            chk("mr_no_ghost", ov4, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
